gray_conv_arbiter: RTL

GRAY_CONV_ARBITER -- requirements
Module: gray_conv_arbiter

---
 rtl/gray_arb_pkg.sv | 11 +
 rtl/bin2gray_n.sv | 12 +
 rtl/gray_conv_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/gray_arb_pkg.sv
// rtl/gray_arb_pkg.sv - shared FSM encoding and default width for the Gray converter arbiter
package gray_arb_pkg;

  localparam int GRAY_ARB_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bin2gray_n.sv
// rtl/bin2gray_n.sv - combinational binary-to-Gray converter, WIDTH bits
module bin2gray_n #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] g
);

  // MSB passes through; every lower bit is the XOR of itself and its upper neighbour
  assign g = b ^ {1'b0, b[WIDTH-1:1]};

endmodule

// File: rtl/gray_conv_arbiter.sv
// rtl/gray_conv_arbiter.sv - two-requester round-robin front end sharing one Gray converter (optional parity via GRAY_ARB_PARITY_EN)
module gray_conv_arbiter
  import gray_arb_pkg::*;
#(
  parameter int WIDTH = GRAY_ARB_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_b,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_b,
  output logic             in1_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_g,
  output logic             out_id,
  output logic [7:0]       conv_cnt
`ifdef GRAY_ARB_PARITY_EN
  ,
  output logic             out_par
`endif
);

  arb_state_t       state;
  logic             rr_ptr;
  logic             grant_vld;
  logic             grant_id;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] gray_val;

  // Grant decision: a lone requester wins outright, a tie goes to rr_ptr
  always_comb begin
    grant_vld = in0_valid | in1_valid;
    grant_id  = 1'b0;
    if (in0_valid && in1_valid) begin
      grant_id = rr_ptr;
    end else if (in1_valid) begin
      grant_id = 1'b1;
    end
    sel_b = grant_id ? in1_b : in0_b;
  end

  // Readies only while out of reset and idle, and only toward the granted requester
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    if (rst_n && (state == IDLE) && grant_vld) begin
      in0_ready = ~grant_id;
      in1_ready = grant_id;
    end
  end

  bin2gray_n #(
    .WIDTH(WIDTH)
  ) u_bin2gray (
    .b(sel_b),
    .g(gray_val)
  );

  // Accept in IDLE, present in HOLD; a handshake cycle never also accepts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      out_valid <= 1'b0;
      out_g     <= '0;
      out_id    <= 1'b0;
      conv_cnt  <= 8'd0;
`ifdef GRAY_ARB_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            out_g     <= gray_val;
            out_id    <= grant_id;
            out_valid <= 1'b1;
            rr_ptr    <= ~grant_id;
`ifdef GRAY_ARB_PARITY_EN
            out_par   <= ^gray_val;
`endif
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            conv_cnt  <= conv_cnt + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
